// File: rtl/tow_pkg.sv
// rtl/tow_pkg.sv - shared round-controller types, LFSR constants and win patterns
package tow_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_LIT  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [23:0] LFSR_SEED = 24'hACE1A5;
  // Taps 24,23,22,17 (1-based) map to bits 23,22,21,16.
  localparam logic [23:0] LFSR_TAPS = 24'hE10000;

  localparam logic [6:0] WIN_LEFT  = 7'b1110000;
  localparam logic [6:0] WIN_RIGHT = 7'b0000111;

  function automatic logic [23:0] lfsr_next(input logic [23:0] cur);
    return {cur[22:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/button_sync.sv
// rtl/button_sync.sv - two-flop synchroniser and rising-edge detector for one pushbutton
module button_sync (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic sync,
  output logic rise
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic prev_q, prev_d;

  always_comb begin
    s1_d   = btn;
    s2_d   = s1_q;
    prev_d = s2_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      prev_q <= prev_d;
    end
  end

  assign sync = s2_q;
  assign rise = s2_q & ~prev_q;

endmodule

// File: rtl/round_ctrl.sv
// rtl/round_ctrl.sv - round sequencing: release wait, random dark delay, lights, first-push report
module round_ctrl
  import tow_pkg::*;
#(
  parameter logic [23:0] DELAY_MIN  = 24'd1_000_000,
  parameter logic [23:0] DELAY_MASK = 24'h3F_FFFF,
  parameter logic [15:0] REL_CYCLES = 16'd50_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pbl,
  input  logic       pbr,
  input  logic [6:0] score,
  output logic       winrnd,
  output logic       right,
  output logic       leds_on
);

  state_e      state_q, state_d;
  logic [23:0] lfsr_q, lfsr_d;
  logic [23:0] dly_q, dly_d;
  logic [15:0] rel_q, rel_d;
  logic        winrnd_q, winrnd_d;
  logic        right_q, right_d;
  logic        leds_on_q, leds_on_d;

  logic sync_l, sync_r, rise_l, rise_r;
  logic any_rise, pick_right, game_over;

  button_sync u_sync_l (.clk(clk), .rst(rst), .btn(pbl), .sync(sync_l), .rise(rise_l));
  button_sync u_sync_r (.clk(clk), .rst(rst), .btn(pbr), .sync(sync_r), .rise(rise_r));

  assign game_over = (score == WIN_LEFT) | (score == WIN_RIGHT);
  assign any_rise  = rise_l | rise_r;
  // A tie goes to whoever is behind; at centre the left player takes it.
  assign pick_right = (rise_l & rise_r) ? (score[6:4] != 3'b000) : rise_r;

  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_next(lfsr_q);
    dly_d     = dly_q;
    rel_d     = '0;
    winrnd_d  = 1'b0;
    right_d   = right_q;
    leds_on_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (game_over) begin
          state_d = ST_DONE;
          right_d = 1'b0;
        end else if (!(sync_l || sync_r)) begin
          rel_d = (rel_q >= REL_CYCLES) ? REL_CYCLES : rel_q + 16'd1;
          if (rel_d == REL_CYCLES) begin
            state_d = ST_WAIT;
            dly_d   = DELAY_MIN + (lfsr_q & DELAY_MASK);
          end
        end
      end
      ST_WAIT: begin
        if (game_over) begin
          state_d = ST_DONE;
          right_d = 1'b0;
        end else if (any_rise) begin
          state_d  = ST_IDLE;
          winrnd_d = 1'b1;
          right_d  = pick_right;
        end else if (dly_q == 24'd0) begin
          state_d   = ST_LIT;
          leds_on_d = 1'b1;
        end else begin
          dly_d = dly_q - 24'd1;
        end
      end
      ST_LIT: begin
        // Lights stay on through the pulse cycle so the push is qualified.
        leds_on_d = 1'b1;
        if (any_rise) begin
          state_d  = ST_IDLE;
          winrnd_d = 1'b1;
          right_d  = pick_right;
        end
      end
      ST_DONE: begin
        right_d = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      lfsr_q    <= LFSR_SEED;
      dly_q     <= '0;
      rel_q     <= '0;
      winrnd_q  <= 1'b0;
      right_q   <= 1'b0;
      leds_on_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      dly_q     <= dly_d;
      rel_q     <= rel_d;
      winrnd_q  <= winrnd_d;
      right_q   <= right_d;
      leds_on_q <= leds_on_d;
    end
  end

  assign winrnd  = winrnd_q;
  assign right   = right_q;
  assign leds_on = leds_on_q;

endmodule

// File: tb/tb_round_ctrl.sv
// tb/tb_round_ctrl.sv - self-checking bench for round_ctrl with a cycle-count reference model
module tb_round_ctrl;

  logic       clk;
  logic       rst;
  logic       pbl;
  logic       pbr;
  logic [6:0] score;
  logic       winrnd;
  logic       right;
  logic       leds_on;

  int checks;
  int errors;
  int cyc;
  int win_count;
  int leds_seen;
  int exp_wins;

  round_ctrl #(
    .DELAY_MIN (24'd10),
    .DELAY_MASK(24'd7),
    .REL_CYCLES(16'd4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .pbl    (pbl),
    .pbr    (pbr),
    .score  (score),
    .winrnd (winrnd),
    .right  (right),
    .leds_on(leds_on)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edges since reset release: during the cycle after edge n, cyc == n.
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (winrnd === 1'b1) win_count++;
    if (leds_on === 1'b1) leds_seen++;
  end

  function automatic logic [23:0] lfsr_adv(input int n);
    logic [23:0] l;
    l = 24'hACE1A5;
    for (int i = 0; i < n; i++) l = {l[22:0], l[23] ^ l[22] ^ l[21] ^ l[16]};
    return l;
  endfunction

  // Dark length loaded when the round arms at edge e (LFSR value held before that edge).
  function automatic int dark_len(input int e);
    return 10 + int'(lfsr_adv(e - 1) & 24'd7);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int p);
    int t;
    t = 0;
    while (cyc < p && t < 500) begin
      @(negedge clk);
      t++;
    end
  endtask

  // Lights must first come on at cyc == e + dark + 1.
  task automatic expect_lit(input int e, input string tag);
    int t;
    t = 0;
    while (leds_on !== 1'b1 && t < 300) begin
      @(negedge clk);
      t++;
    end
    check(tag, cyc, e + dark_len(e) + 1);
  endtask

  // Drive at the current negedge; pulse is due three edges later.
  task automatic push(input logic l, input logic r, input logic exp_right,
                      input logic exp_leds, input string tag);
    int n, t;
    pbl = l;
    pbr = r;
    n = cyc;
    exp_wins++;
    t = 0;
    while (winrnd !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_lat"}, cyc, n + 3);
    check({tag, "_right"}, right, exp_right);
    check({tag, "_leds"}, leds_on, exp_leds);
    @(negedge clk);
    check({tag, "_width"}, winrnd, 1'b0);
    check({tag, "_leds_drop"}, leds_on, 1'b0);
  endtask

  // Release both buttons; the next round arms six edges later.
  task automatic rel(output int e);
    @(negedge clk);
    pbl = 1'b0;
    pbr = 1'b0;
    e = cyc + 6;
    check("win_count", win_count, exp_wins);
  endtask

  logic [6:0] sc_tab [6];
  logic [6:0] sc;
  int e, d, p, ls0, wc0, mode, who;
  logic exp_r;

  initial begin
    sc_tab[0] = 7'b0001000; sc_tab[1] = 7'b0010000; sc_tab[2] = 7'b0110000;
    sc_tab[3] = 7'b0000100; sc_tab[4] = 7'b0000110; sc_tab[5] = 7'b0100000;
    checks = 0; errors = 0; win_count = 0; leds_seen = 0; exp_wins = 0;
    pbl = 1'b0; pbr = 1'b0; rst = 1'b0; score = 7'b0001000;
    repeat (3) @(negedge clk);
    check("rst_winrnd", winrnd, 1'b0);
    check("rst_right", right, 1'b0);
    check("rst_leds", leds_on, 1'b0);
    rst = 1'b1;
    e = 4;
    expect_lit(e, "first_lit");
    check("no_win_first", win_count, 0);

    repeat (2) @(negedge clk);
    push(1'b0, 1'b1, 1'b1, 1'b1, "lit_right");
    rel(e);

    d = dark_len(e);
    wait_cyc(e + 2);
    ls0 = leds_seen;
    push(1'b1, 1'b0, 1'b0, 1'b0, "jump_left");
    rel(e);
    check("jump_no_lights", leds_seen, ls0);
    expect_lit(e, "after_jump_lit");

    score = 7'b0100000;
    push(1'b1, 1'b1, 1'b1, 1'b1, "tie_left_ahead");
    rel(e);
    expect_lit(e, "tie1_lit");
    score = 7'b0001000;
    push(1'b1, 1'b1, 1'b0, 1'b1, "tie_centre");
    rel(e);
    expect_lit(e, "tie2_lit");

    push(1'b0, 1'b1, 1'b1, 1'b1, "held_right");
    repeat (12) @(negedge clk);
    check("held_one_win", win_count, exp_wins);
    rel(e);

    for (int i = 0; i < 6; i++) begin
      sc = sc_tab[$urandom_range(0, 5)];
      score = sc;
      mode = $urandom_range(0, 1);
      who = $urandom_range(0, 2);
      exp_r = (who == 2) ? (sc[6:4] != 3'b000) : (who == 1);
      if (mode == 0) begin
        expect_lit(e, "rnd_lit");
        repeat ($urandom_range(0, 4)) @(negedge clk);
        push(who != 1, who != 0, exp_r, 1'b1, "rnd_lit_push");
      end else begin
        d = dark_len(e);
        p = e + $urandom_range(0, d - 2);
        wait_cyc(p);
        push(who != 1, who != 0, exp_r, 1'b0, "rnd_jump_push");
      end
      repeat ($urandom_range(0, 6)) @(negedge clk);
      rel(e);
    end

    expect_lit(e, "pre_rst_lit");
    push(1'b0, 1'b1, 1'b1, 1'b1, "pre_rst_push");
    rel(e);
    wait_cyc(e + 3);
    check("right_holds", right, 1'b1);
    check("wait_dark", leds_on, 1'b0);
    pbr = 1'b1;
    rst = 1'b0;
    #1;
    check("midrst_right", right, 1'b0);
    check("midrst_winrnd", winrnd, 1'b0);
    check("midrst_leds", leds_on, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (8) @(negedge clk);
    check("held_after_rst_dark", leds_on, 1'b0);
    rel(e);
    expect_lit(e, "post_rst_lit");

    push(1'b0, 1'b1, 1'b1, 1'b1, "pre_done_push");
    score = 7'b0000111;
    rel(e);
    ls0 = leds_seen;
    wc0 = win_count;
    repeat (40) @(negedge clk);
    check("done_right", right, 1'b0);
    check("done_no_lights", leds_seen, ls0);
    pbl = 1'b1;
    repeat (10) @(negedge clk);
    check("done_no_win", win_count, wc0);
    check("done_winrnd", winrnd, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/round_ctrl.md
# round_ctrl

Round controller directly upstream of `scorer`. Synchronises the two player pushbuttons and runs each round: wait for release, random dark delay, then lights on. It then reports the first push as a one-cycle `winrnd` pulse with stable `right` and `leds_on` qualifiers. It freezes once `scorer` reports a win.

## Interface
Parameters:
- `DELAY_MIN`, default 24'd1_000_000: minimum dark-phase length in cycles.
- `DELAY_MASK`, default 24'h3F_FFFF: AND-mask applied to the LFSR for the random extra delay.
- `REL_CYCLES`, default 16'd50_000: consecutive both-released cycles required before a round arms.

Ports:
- `clk` in 1: single system clock.
- `rst` in 1: reset. One clock; reset is asynchronous and active-low.
- `pbl` in 1: left pushbutton, active-high, asynchronous to `clk`.
- `pbr` in 1: right pushbutton, active-high, asynchronous to `clk`.
- `score` in 7: scorer output, format [L3 L2 L1 N R1 R2 R3].
- `winrnd` out 1: one-cycle pulse, a push was accepted.
- `right` out 1: 1 = right player pushed first, 0 = left.
- `leds_on` out 1: lights lit; qualifies the push (0 = jumped the light).

## Operation
- Input path: each button passes through a 2-flop synchroniser, then a rising-edge detector (`sync & ~prev`). Only edges count as pushes; held buttons never re-trigger.
- `game_over` = (`score` == 7'b1110000) | (`score` == 7'b0000111).
- 24-bit Fibonacci LFSR, taps 24,23,22,17, seed 24'hACE1A5. It advances every cycle, including during reset release, and is never all-zero.
- FSM states: IDLE, WAIT, LIT, DONE.
  - **IDLE**: `leds_on`=0. The release counter counts cycles with both synced buttons low and clears on any press. When the count reaches REL_CYCLES, go to WAIT and load `dly` = DELAY_MIN + (lfsr & DELAY_MASK).
  - **WAIT**: `leds_on`=0; `dly` decrements each cycle. A push edge here is a jumped light: pulse `winrnd` with `leds_on`=0, then return to IDLE. At `dly`==0 with no push, go to LIT.
  - **LIT**: `leds_on`=1 and held until a push. A push edge pulses `winrnd` with `leds_on`=1, then returns to IDLE. `leds_on` stays 1 on the pulse cycle and drops the next cycle.
  - **DONE**: entered from IDLE or WAIT when `game_over`=1. All outputs are 0 and pushes are ignored. The only exit is reset.
- `right` is registered with `winrnd` and holds its value until the next `winrnd`.
- Simultaneous edges on the same cycle favour the loser:
  - right wins (`right`=1) if `score[6:4]` != 0 (left ahead);
  - left wins if `score[2:0]` != 0;
  - at N, left wins.
- Second player's edge within the same round is ignored (FSM already in IDLE).
- Arithmetic: `dly` is 24-bit. DELAY_MIN + masked LFSR must not exceed 2^24-1, and this is the integrator's responsibility. Release counter is 16-bit and saturates at REL_CYCLES.

## Timing
- Reset values: state IDLE, `winrnd`=0, `right`=0, `leds_on`=0, release counter 0, LFSR = seed, synchroniser flops 0.
- Push-to-`winrnd` latency: 3 cycles from the first `clk` edge sampling the button high. That is 2 synchroniser flops plus 1 registered output.
- `winrnd` is exactly 1 cycle wide. `right` and `leds_on` are valid on the same cycle, as `scorer` samples them.
- `scorer` updates `score` the cycle after `winrnd`. `game_over` is therefore checked only in IDLE/WAIT, never on the `winrnd` cycle.
- WAIT-to-LIT happens on the cycle `dly` reaches 0. Dark phase is DELAY_MIN + (lfsr & DELAY_MASK) + 1 cycles.
- Reset mid-round: immediate return to IDLE with outputs 0; a held button must be released before the next round.

## Structure
- Shared package `tow_pkg`: FSM state encoding (2-bit IDLE=0, WAIT=1, LIT=2, DONE=3), LFSR seed and tap mask, and the two win patterns 7'b1110000 / 7'b0000111.
- Sub-module `button_sync`: 2-flop synchroniser plus edge detector, instantiated once per button.
- LFSR, counters and FSM stay in `round_ctrl`.

## Test plan
All scenarios use DELAY_MIN=10, DELAY_MASK=7, REL_CYCLES=4.
- Reset, buttons low → after 4 cycles in IDLE enters WAIT; `leds_on` rises after 11–18 cycles; `winrnd` stays 0.
- In LIT, assert `pbr` → `winrnd`=1 for one cycle 3 cycles later with `right`=1, `leds_on`=1; FSM back in IDLE.
- In WAIT, assert `pbl` → `winrnd` pulse with `right`=0, `leds_on`=0; lights never turn on this round.
- In LIT, assert `pbl` and `pbr` on the same edge:
  - `score`=7'b0100000 → `right`=1;
  - `score`=7'b0001000 → `right`=0.
- Hold `pbr` high across the return to IDLE → no new round until released for 4 cycles; exactly one `winrnd` per press.
- Drive `score`=7'b0000111 while in IDLE → DONE; subsequent presses give no `winrnd`. Deassert `rst` mid-WAIT → outputs 0 immediately; state IDLE.
